// File: rtl/uart_tx_drain.sv
// uart_tx_drain
// Pulls one byte at a time from an upstream synchronous FIFO and shifts it out
// as a single UART 8N1 frame (start bit, 8 data bits LSB first, stop bit).
// Only one byte is ever in flight. The next byte is requested after the
// current stop bit has finished.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  // Width of the bit-period counter. It is kept at least 1 bit wide so the
  // smallest legal CLKS_PER_BIT still gives a valid vector.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             bit_end;

  // Last clock of the current bit period.
  assign bit_end = (bit_cnt == CNT_LAST);

  // busy is the only output decoded directly from state.
  assign busy = (state != IDLE);

  // Frame sequencer. All outputs except busy are registered here.
  // tx is only driven low in the WAIT->START transition and inside DATA,
  // so the line cannot dip outside the start and data bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_cnt <= '0;
          bit_idx <= 3'd0;
          if (!fifo_empty) begin
            state      <= FETCH;
            fifo_rd_en <= 1'b1;
          end
        end
        // The read strobe is high during this cycle. The FIFO presents the
        // data one cycle later.
        FETCH: begin
          state <= WAIT;
        end
        // The FIFO output is valid now. Latch it and begin the start bit.
        WAIT: begin
          shift_reg <= fifo_data;
          tx        <= 1'b0;
          bit_cnt   <= '0;
          state     <= START;
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            tx      <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // Shift right so the next data bit is always shift_reg[1] at the
        // bit boundary.
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            bit_cnt <= '0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain.
// The fast instance (4 clocks per bit) is driven by a queue-based FIFO model.
// The slow instance (868 clocks per bit) is driven directly by the bench.
// Expected line activity is derived from the UART 8N1 frame definition:
// - 10 bit slots, each 4 clocks long;
// - 3 idle clocks between back-to-back frames.
module tb_uart_tx_drain;

  localparam int C      = 4;
  localparam int C_SLOW = 868;
  localparam int FRAME  = 10 * C;
  localparam int PITCH  = FRAME + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       tx, busy, tx_done;

  logic       fifo2_empty = 1'b1;
  logic       fifo2_rd_en;
  logic [7:0] fifo2_data = 8'h00;
  logic       tx2, busy2, tx2_done;

  int checks = 0;
  int failures = 0;

  byte unsigned fq[$];
  byte unsigned exp_q[$];
  bit           noise_en = 1'b0;
  int           rd_empty_cnt = 0;

  bit log_en = 1'b0;
  bit tx_log[$], rd_log[$], done_log[$], empty_log[$];

  uart_tx_drain #(.CLKS_PER_BIT(C)) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_drain #(.CLKS_PER_BIT(C_SLOW)) u_dut_slow (
    .clk(clk), .reset(reset), .fifo_empty(fifo2_empty), .fifo_rd_en(fifo2_rd_en),
    .fifo_data(fifo2_data), .tx(tx2), .busy(busy2), .tx_done(tx2_done)
  );

  always #5 clk = ~clk;

  // FIFO model: the read data is registered.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() > 0) fifo_data <= fq.pop_front();
      else rd_empty_cnt++;
    end
  end

  // FIFO model: the empty flag, optionally overridden by random noise.
  always @(negedge clk) begin
    #1;
    if (noise_en) fifo_empty = 1'($urandom_range(0, 1));
    else fifo_empty = (fq.size() == 0);
  end

  // Per-cycle log of the fast instance.
  always @(posedge clk) begin
    #1;
    if (log_en) begin
      tx_log.push_back(tx);
      rd_log.push_back(fifo_rd_en);
      done_log.push_back(tx_done);
      empty_log.push_back(fifo_empty);
    end
  end

  task automatic clear_log();
    log_en = 1'b0;
    tx_log.delete();
    rd_log.delete();
    done_log.delete();
    empty_log.delete();
  endtask

  // Compare the log against back-to-back frames of exp_q.
  task automatic check_stream(input string tag, input bit chk_lat);
    int n, f0, e0, fj, mism, first_bad, rd_cnt, done_cnt, idx;
    logic [7:0] b, d;
    logic e;
    n  = exp_q.size();
    f0 = -1;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] == 1'b0) begin f0 = i; break; end
    end
    checks++;
    if (f0 < 0) begin
      failures++;
      $display("FAIL %s start_edge: got no start edge, want one", tag);
      return;
    end
    if (chk_lat) begin
      e0 = -1;
      for (int i = 0; i < empty_log.size(); i++) begin
        if (empty_log[i] == 1'b0) begin e0 = i; break; end
      end
      // empty first sampled low at edge e0. The start edge lands two edges
      // later, which is three clock edges after the flag deasserted.
      checks++;
      if (e0 < 0 || f0 - e0 != 2) begin
        failures++;
        $display("FAIL %s latency: got %0d, want 2", tag, f0 - e0);
      end
    end
    rd_cnt   = 0;
    done_cnt = 0;
    foreach (rd_log[i]) if (rd_log[i]) rd_cnt++;
    foreach (done_log[i]) if (done_log[i]) done_cnt++;
    for (int j = 0; j < n; j++) begin
      fj = f0 + j * PITCH;
      b  = exp_q[j];
      mism = 0;
      first_bad = -1;
      for (int i = 0; i < FRAME + 3; i++) begin
        if (i < C) e = 1'b0;
        else if (i < 9 * C) e = b[i / C - 1];
        else e = 1'b1;
        if (fj + i >= tx_log.size() || tx_log[fj + i] !== e) begin
          mism++;
          if (first_bad < 0) first_bad = i;
        end
      end
      checks++;
      if (mism != 0) begin
        failures++;
        $display("FAIL %s frame%0d_wave: got %0d bad samples (first at %0d), want 0", tag, j, mism, first_bad);
      end
      for (int k = 0; k < 8; k++) begin
        idx = fj + C * (k + 1) + C / 2;
        d[k] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
      end
      checks++;
      if (d !== b) begin
        failures++;
        $display("FAIL %s frame%0d_decode: got %02h, want %02h", tag, j, d, b);
      end
      checks++;
      if (fj - 2 < 0 || fj - 2 >= rd_log.size() || rd_log[fj - 2] !== 1'b1) begin
        failures++;
        $display("FAIL %s frame%0d_rd_pos: got no rd_en 2 cycles before start, want 1", tag, j);
      end
      checks++;
      if (fj + FRAME >= done_log.size() || done_log[fj + FRAME] !== 1'b1) begin
        failures++;
        $display("FAIL %s frame%0d_done_pos: got no tx_done at frame end, want 1", tag, j);
      end
    end
    checks++;
    if (rd_cnt != n) begin
      failures++;
      $display("FAIL %s rd_count: got %0d, want %0d", tag, rd_cnt, n);
    end
    checks++;
    if (done_cnt != n) begin
      failures++;
      $display("FAIL %s done_count: got %0d, want %0d", tag, done_cnt, n);
    end
    checks++;
    if (rd_empty_cnt != 0) begin
      failures++;
      $display("FAIL %s rd_on_empty: got %0d, want 0", tag, rd_empty_cnt);
    end
    $display("%s: %0d frame(s) examined", tag, n);
  endtask

  task automatic test_reset();
    int bad_tx, bad_busy, bad_rd, bad_done;
    repeat (5) @(negedge clk);
    checks++;
    if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_state: got tx/busy/rd/done=%b, want 1000", {tx, busy, fifo_rd_en, tx_done});
    end
    reset = 1'b0;
    bad_tx = 0; bad_busy = 0; bad_rd = 0; bad_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (tx_done !== 1'b0) bad_done++;
    end
    checks++; if (bad_tx != 0)   begin failures++; $display("FAIL idle_tx: got %0d low cycles, want 0", bad_tx); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL idle_busy: got %0d busy cycles, want 0", bad_busy); end
    checks++; if (bad_rd != 0)   begin failures++; $display("FAIL idle_rd_en: got %0d strobes, want 0", bad_rd); end
    checks++; if (bad_done != 0) begin failures++; $display("FAIL idle_tx_done: got %0d pulses, want 0", bad_done); end
    $display("test_reset: 50 idle cycles observed");
  endtask

  task automatic test_single_byte();
    clear_log();
    log_en = 1'b1;
    repeat (3) @(negedge clk);
    exp_q = {8'hA5};
    fq.push_back(8'hA5);
    repeat (FRAME + 20) @(negedge clk);
    check_stream("single_a5", 1'b1);
  endtask

  task automatic test_back_to_back();
    clear_log();
    log_en = 1'b1;
    repeat (3) @(negedge clk);
    exp_q = {8'h00, 8'hFF, 8'h55};
    fq.push_back(8'h00); fq.push_back(8'hFF); fq.push_back(8'h55);
    repeat (3 * PITCH + 20) @(negedge clk);
    check_stream("back_to_back", 1'b1);
  endtask

  task automatic test_random_stream();
    byte unsigned v;
    clear_log();
    log_en = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      exp_q.push_back(v);
      fq.push_back(v);
    end
    repeat (4 * PITCH + 20) @(negedge clk);
    check_stream("random_stream", 1'b1);
  endtask

  task automatic test_empty_noise();
    byte unsigned v;
    bit seen;
    clear_log();
    log_en = 1'b1;
    repeat (2) @(negedge clk);
    v = 8'($urandom);
    exp_q = {v};
    fq.push_back(v);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL noise_start: got no start edge within 20 cycles, want one"); end
    noise_en = 1'b1;
    repeat (30) @(negedge clk);
    noise_en = 1'b0;
    repeat (25) @(negedge clk);
    check_stream("empty_noise", 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    byte unsigned a, b;
    bit seen;
    clear_log();
    a = 8'($urandom);
    b = 8'($urandom);
    fq.push_back(a);
    fq.push_back(b);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midreset_start: got no start edge within 20 cycles, want one"); end
    // From cycle 0 of the start bit, step into data bit 3.
    repeat (4 * C + 1) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: got tx=%b busy=%b rd=%b, want tx=1 busy=0 rd=0", tx, busy, fifo_rd_en);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fq.size() != 1) begin
      failures++;
      $display("FAIL midreset_fifo_level: got %0d bytes left, want 1", fq.size());
    end
    log_en = 1'b1;
    reset = 1'b0;
    exp_q = {b};
    repeat (FRAME + 20) @(negedge clk);
    check_stream("reset_mid_frame", 1'b0);
  endtask

  task automatic test_slow_baud();
    bit seen;
    int mism, rd_extra, done_early;
    logic [9:0] frame_bits;
    logic [7:0] d;
    // Frame bits in line order: start=0, data LSB first, stop=1.
    frame_bits = {1'b1, 8'h3C, 1'b0};
    fifo2_empty = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (fifo2_rd_en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL slow_rd_en: got no read strobe within 10 cycles, want one"); end
    fifo2_empty = 1'b1;
    fifo2_data  = 8'h3C;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (tx2 === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL slow_start: got no start edge within 10 cycles, want one"); end
    mism = 0;
    rd_extra = 0;
    done_early = 0;
    d = 8'h00;
    // The first negedge after the fall is cycle 0 of the start bit.
    for (int i = 0; i < 10 * C_SLOW; i++) begin
      if (tx2 !== frame_bits[i / C_SLOW]) mism++;
      if (fifo2_rd_en !== 1'b0) rd_extra++;
      if (tx2_done !== 1'b0) done_early++;
      if (i >= C_SLOW && i < 9 * C_SLOW && (i % C_SLOW) == C_SLOW / 2) d[i / C_SLOW - 1] = tx2;
      @(negedge clk);
    end
    checks++;
    if (mism != 0) begin failures++; $display("FAIL slow_wave: got %0d bad cycles, want 0", mism); end
    checks++;
    if (d !== 8'h3C) begin failures++; $display("FAIL slow_decode: got %02h, want 3c", d); end
    checks++;
    if (rd_extra != 0) begin failures++; $display("FAIL slow_extra_rd: got %0d strobes, want 0", rd_extra); end
    checks++;
    if (done_early != 0) begin failures++; $display("FAIL slow_done_early: got %0d pulses, want 0", done_early); end
    checks++;
    if (tx2_done !== 1'b1 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL slow_frame_end: got done=%b tx=%b busy=%b at cycle 8680, want 1 1 0", tx2_done, tx2, busy2);
    end
    $display("test_slow_baud: 8680-cycle frame examined");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_random_stream();
    test_empty_noise();
    test_reset_mid_frame();
    test_slow_baud();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
